// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - instruction-memory requester with RD_WAIT read timing and a 2-entry prefetch queue
// Optional: IFETCH_ALIGN_FAULT_EN turns misaligned redirects into an exception-vector fetch with an AlignFault pulse.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'hF000_0000,
  parameter int unsigned RD_WAIT    = 2
) (
  input  logic        CLK,
  input  logic        Reset_L,
  output logic [31:0] Address,
  input  logic [31:0] Data,
  output logic [31:0] InstrOut,
  output logic [31:0] PCOut,
  output logic [31:0] PCPlus4,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Exception,
  output logic        AlignFault
);

  typedef enum logic {S_WAIT, S_CAPTURE} state_t;

  localparam logic [3:0] WAIT_INIT   = 4'(RD_WAIT - 1);
  localparam state_t     RESET_STATE = (WAIT_INIT == 4'd0) ? S_CAPTURE : S_WAIT;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0] instr0_q, instr0_d, instr1_q, instr1_d;

  logic        pop;
  logic        push;
  logic        flush_to_vector;
  logic        redirect_fault;
  logic [1:0]  after_pop;

`ifdef IFETCH_ALIGN_FAULT_EN
  logic align_fault_q, align_fault_d;
  assign redirect_fault = Redirect && (RedirectPC[1:0] != 2'b00);
  assign align_fault_d  = redirect_fault && !Exception;
  assign AlignFault     = align_fault_q;
`else
  assign redirect_fault = 1'b0;
  assign AlignFault     = 1'b0;
`endif

  assign flush_to_vector = Exception || redirect_fault;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wait_cnt_d = wait_cnt_q;
    count_d    = count_q;
    pc0_d      = pc0_q;
    pc1_d      = pc1_q;
    instr0_d   = instr0_q;
    instr1_d   = instr1_q;

    pop       = (count_q != 2'd0) && InstrReady;
    push      = (state_q == S_CAPTURE) && ((count_q != 2'd2) || pop);
    after_pop = count_q - {1'b0, pop};

    if (flush_to_vector) begin
      count_d    = 2'd0;
      fetch_pc_d = EXC_VECTOR;
      wait_cnt_d = WAIT_INIT;
    end else if (Redirect) begin
      count_d    = 2'd0;
      fetch_pc_d = RedirectPC & ~32'h3;
      wait_cnt_d = WAIT_INIT;
    end else begin
      case (state_q)
        S_WAIT:    wait_cnt_d = wait_cnt_q - 4'd1;
        S_CAPTURE: begin
          // Without room in the queue the address is held and the word re-sampled later.
          if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            wait_cnt_d = WAIT_INIT;
          end
        end
        default:   wait_cnt_d = WAIT_INIT;
      endcase

      if (pop) begin
        pc0_d    = pc1_q;
        instr0_d = instr1_q;
      end
      if (push) begin
        if (after_pop == 2'd0) begin
          pc0_d    = fetch_pc_q;
          instr0_d = Data;
        end else begin
          pc1_d    = fetch_pc_q;
          instr1_d = Data;
        end
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    state_d = (wait_cnt_d == 4'd0) ? S_CAPTURE : S_WAIT;
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q    <= RESET_STATE;
      fetch_pc_q <= RESET_PC;
      wait_cnt_q <= WAIT_INIT;
      count_q    <= 2'd0;
      pc0_q      <= 32'h0;
      pc1_q      <= 32'h0;
      instr0_q   <= 32'h0;
      instr1_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wait_cnt_q <= wait_cnt_d;
      count_q    <= count_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
      instr0_q   <= instr0_d;
      instr1_q   <= instr1_d;
    end
  end

`ifdef IFETCH_ALIGN_FAULT_EN
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      align_fault_q <= 1'b0;
    end else begin
      align_fault_q <= align_fault_d;
    end
  end
`endif

  assign Address    = fetch_pc_q;
  assign InstrValid = (count_q != 2'd0);
  assign InstrOut   = InstrValid ? instr0_q : 32'h0;
  assign PCOut      = InstrValid ? pc0_q : 32'h0;
  assign PCPlus4    = InstrValid ? (pc0_q + 32'd4) : 32'h0;

endmodule
